// File: rtl/central_fsm_pkg.sv
// Shared key codes, state/setting encodings and value limits for the
// elevator-simulator central control FSM.
package central_fsm_pkg;

  localparam logic [3:0] KEY_STOP   = 4'hA;
  localparam logic [3:0] KEY_RESUME = 4'hB;
  localparam logic [3:0] KEY_UP     = 4'hC;
  localparam logic [3:0] KEY_DOWN   = 4'hD;
  localparam logic [3:0] KEY_ESC    = 4'hE;
  localparam logic [3:0] KEY_ENTER  = 4'hF;

  typedef enum logic [1:0] {
    SIM_IDLE = 2'd0,
    SIM_RUN  = 2'd1,
    SIM_STOP = 2'd2
  } sim_state_e;

  typedef enum logic [1:0] {
    SET_PEOPLE = 2'd0,
    SET_SPEED  = 2'd1,
    SET_RSV2   = 2'd2,
    SET_RSV3   = 2'd3
  } setting_e;

  localparam logic [5:0] MAX_PEOPLE = 6'd63;
  localparam logic [2:0] MAX_SPEED  = 3'd7;
  localparam logic [1:0] MAX_DIGITS = 2'd2;
  localparam logic [2:0] SPEED_RST  = 3'd1;

endpackage

// File: rtl/central_fsm_if.sv
// Keypad inputs and configuration/state outputs of the central control FSM.
interface central_fsm_if;
  logic [3:0] buttonBus;
  logic       pressed;
  logic [1:0] simState;
  logic [1:0] setting;
  logic [2:0] simSpeed;
  logic [5:0] people;

  modport master (
    output buttonBus, pressed,
    input  simState, setting, simSpeed, people
  );

  modport slave (
    input  buttonBus, pressed,
    output simState, setting, simSpeed, people
  );
endinterface

// File: rtl/central_fsm_press_edge.sv
// Registers the keypad level and emits one event pulse per low-to-high press.
module press_edge (
  input  logic clk,
  input  logic rst,
  input  logic pressed_i,
  output logic event_o
);

  logic pressed_q;
  logic pressed_d;

  always_comb begin
    pressed_d = pressed_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pressed_q <= 1'b0;
    else     pressed_q <= pressed_d;
  end

  assign event_o = pressed_i & ~pressed_q;

endmodule

// File: rtl/central_fsm.sv
// Central control FSM: decodes keypad press events into run/stop state,
// the selected setting, and the speed/passenger configuration registers.
module central_fsm
  import central_fsm_pkg::*;
(
  input logic          clk,
  input logic          rst,
  central_fsm_if.slave bus
);

  sim_state_e state_q, state_d;
  logic [1:0] setting_q, setting_d;
  logic [2:0] speed_q, speed_d;
  logic [5:0] people_q, people_d;
  logic [6:0] buf_q, buf_d;
  logic [1:0] cnt_q, cnt_d;
  logic       key_evt;
  logic [3:0] key;

  function automatic logic [5:0] sat_people(input logic [6:0] v);
    return (v > {1'b0, MAX_PEOPLE}) ? MAX_PEOPLE : v[5:0];
  endfunction

  function automatic logic [2:0] sat_speed(input logic [6:0] v);
    return (v > {4'b0, MAX_SPEED}) ? MAX_SPEED : v[2:0];
  endfunction

  press_edge u_press_edge (
    .clk       (clk),
    .rst       (rst),
    .pressed_i (bus.pressed),
    .event_o   (key_evt)
  );

  assign key = bus.buttonBus;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SIM_IDLE;
      setting_q <= SET_PEOPLE;
      speed_q   <= SPEED_RST;
      people_q  <= 6'd0;
      buf_q     <= 7'd0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      setting_q <= setting_d;
      speed_q   <= speed_d;
      people_q  <= people_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    setting_d = setting_q;
    speed_d   = speed_q;
    people_d  = people_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    if (key_evt) begin
      case (key)
        KEY_STOP: begin
          if (state_q == SIM_RUN) state_d = SIM_STOP;
        end
        KEY_RESUME: begin
          if (state_q != SIM_RUN) state_d = SIM_RUN;
        end
        KEY_ESC: begin
          if (state_q == SIM_STOP) state_d = SIM_IDLE;
          buf_d = 7'd0;
          cnt_d = 2'd0;
        end
        // The entry buffer is cleared only when the setting actually moves.
        KEY_UP: begin
          if (setting_q != SET_RSV3) begin
            setting_d = setting_q + 2'd1;
            buf_d     = 7'd0;
            cnt_d     = 2'd0;
          end
        end
        KEY_DOWN: begin
          if (setting_q != SET_PEOPLE) begin
            setting_d = setting_q - 2'd1;
            buf_d     = 7'd0;
            cnt_d     = 2'd0;
          end
        end
        KEY_ENTER: begin
          if (cnt_q != 2'd0) begin
            if (setting_q == SET_PEOPLE)     people_d = sat_people(buf_q);
            else if (setting_q == SET_SPEED) speed_d  = sat_speed(buf_q);
          end
          buf_d = 7'd0;
          cnt_d = 2'd0;
        end
        // Remaining codes are digits; at most two digits keep buf_q <= 99.
        default: begin
          if (cnt_q < MAX_DIGITS) begin
            buf_d = (buf_q * 7'd10) + {3'b0, key};
            cnt_d = cnt_q + 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.simState = state_q;
  assign bus.setting  = setting_q;
  assign bus.simSpeed = speed_q;
  assign bus.people   = people_q;

endmodule

// File: tb/tb_central_fsm.sv
// Directed self-checking bench for central_fsm.
module tb_central_fsm;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  central_fsm_if ifc ();

  central_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int se, input int sp, input int pe);
    chk({tag, ".simState"}, {6'b0, ifc.simState}, 8'(st));
    chk({tag, ".setting"},  {6'b0, ifc.setting},  8'(se));
    chk({tag, ".simSpeed"}, {5'b0, ifc.simSpeed}, 8'(sp));
    chk({tag, ".people"},   {2'b0, ifc.people},   8'(pe));
  endtask

  // One clean press: high for one sampled edge, then low for one edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    ifc.buttonBus = k;
    ifc.pressed   = 1'b1;
    @(negedge clk);
    ifc.pressed   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst           = 1'b1;
    ifc.pressed   = 1'b0;
    ifc.buttonBus = 4'h0;
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 1, 0);
    rst = 1'b0;

    press(4'hB); chk("resume1", {6'b0, ifc.simState}, 8'd1);
    press(4'hA); chk("stop1",   {6'b0, ifc.simState}, 8'd2);
    press(4'hB); chk("resume2", {6'b0, ifc.simState}, 8'd1);
    press(4'hA); chk("stop2",   {6'b0, ifc.simState}, 8'd2);
    press(4'hA); chk("stop_in_stop", {6'b0, ifc.simState}, 8'd2);
    press(4'hB); chk("resume3", {6'b0, ifc.simState}, 8'd1);

    press(4'hC); chk("up1", {6'b0, ifc.setting}, 8'd1);
    press(4'hC); chk("up2", {6'b0, ifc.setting}, 8'd2);
    press(4'hC); chk("up3", {6'b0, ifc.setting}, 8'd3);
    press(4'hC); chk("up_sat", {6'b0, ifc.setting}, 8'd3);
    press(4'hD); press(4'hD);
    press(4'hD); chk("down_to0", {6'b0, ifc.setting}, 8'd0);
    press(4'hD); chk("down_sat", {6'b0, ifc.setting}, 8'd0);
    chk("run_kept", {6'b0, ifc.simState}, 8'd1);

    press(4'h4); press(4'h5);
    chk("people_before_enter", {2'b0, ifc.people}, 8'd0);
    press(4'hF); chk("people45", {2'b0, ifc.people}, 8'd45);
    press(4'h9); press(4'h9); press(4'hF);
    chk("people_clamp", {2'b0, ifc.people}, 8'd63);

    press(4'hC);
    press(4'h9); press(4'hF); chk("speed_clamp", {5'b0, ifc.simSpeed}, 8'd7);
    press(4'h3); press(4'hF); chk("speed3", {5'b0, ifc.simSpeed}, 8'd3);
    chk("people_untouched", {2'b0, ifc.people}, 8'd63);

    press(4'hD);
    press(4'h1); press(4'h2); press(4'h3); press(4'hF);
    chk("third_digit_ignored", {2'b0, ifc.people}, 8'd12);
    press(4'h5); press(4'hE); press(4'hF);
    chk("esc_then_enter", {2'b0, ifc.people}, 8'd12);
    chk("esc_in_run", {6'b0, ifc.simState}, 8'd1);

    // Reserved setting discards the entered value.
    press(4'hC); press(4'hC);
    press(4'h7); press(4'hF);
    chk_all("rsv_discard", 1, 2, 3, 12);
    press(4'hD); press(4'hD);

    // Held press with a bus change mid-hold: exactly one UP.
    @(negedge clk);
    ifc.buttonBus = 4'hC;
    ifc.pressed   = 1'b1;
    @(negedge clk);
    ifc.buttonBus = 4'hD;
    repeat (4) @(negedge clk);
    chk("held_up", {6'b0, ifc.setting}, 8'd1);
    ifc.pressed = 1'b0;
    @(negedge clk);
    chk("release_no_action", {6'b0, ifc.setting}, 8'd1);
    press(4'hD);

    press(4'hA); press(4'hE);
    chk("stop_esc_idle", {6'b0, ifc.simState}, 8'd0);

    // Asynchronous reset in the middle of an entry.
    press(4'hB); press(4'hC);
    press(4'h4);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 1, 0);
    @(negedge clk);
    ifc.buttonBus = 4'hB;
    ifc.pressed   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("press_through_rst", {6'b0, ifc.simState}, 8'd1);
    ifc.pressed = 1'b0;
    @(negedge clk);
    press(4'h2); press(4'hF);
    chk("buf_cleared_by_rst", {2'b0, ifc.people}, 8'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
